// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback queue.
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;

    // Register 0 is hardwired to zero: writes to it are dropped and it never forwards.
    localparam logic [WB_ADDR_WIDTH-1:0] ZERO_REG = '0;

    // One pending writeback: destination register index plus value.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd_idx;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Forwarding lookup: finds the youngest valid queue entry whose destination
// matches the query index. Purely combinational.
module wbq_match
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int PW         = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] ent_reg_i  [DEPTH],
    input  logic [DATA_WIDTH-1:0] ent_data_i [DEPTH],
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [PW-1:0]         wr_ptr_i,
    input  logic [ADDR_WIDTH-1:0] query_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] match;
    logic             query_nonzero;

    assign query_nonzero = (query_i != ADDR_WIDTH'(ZERO_REG));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = valid_i[gi] && (ent_reg_i[gi] == query_i) && query_nonzero;
        end
    endgenerate

    // Walk slots from oldest (wr_ptr) to youngest (wr_ptr-1); later hits override earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr_i - PW'(k);
            if (match[idx]) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the register file write port.
// Buffers up to DEPTH writes, drains one per cycle, and forwards the youngest
// pending value to two read ports so reads stay coherent with queued writes.
module regfile_wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_reg,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_we,
    output logic [ADDR_WIDTH-1:0]    out_reg,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_b,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic [DATA_WIDTH-1:0]    fwd_data_a,
    output logic [DATA_WIDTH-1:0]    fwd_data_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Entry payload storage; never reset, only qualified by valid_q.
    logic [ADDR_WIDTH-1:0] reg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [CW-1:0]    count_q,  count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] valid_q,  valid_d;

    logic push;
    logic store;
    logic pop;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready = (count_q < DEPTH_C);
    assign out_we   = (count_q != '0);
    assign out_reg  = out_we ? reg_mem[rd_ptr_q]  : '0;
    assign out_data = out_we ? data_mem[rd_ptr_q] : '0;
    assign count    = count_q;

    // A write to register 0 completes the handshake but is not queued.
    assign push  = in_valid && in_ready;
    assign store = push && (in_reg != ADDR_WIDTH'(ZERO_REG));
    assign pop   = out_we && out_ready;

    // Next-state for pointers, valid bits and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (store) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(store) - CW'(pop);
    end

    // Control state, cleared immediately by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Capture the payload of an accepted, non-zero-destination write.
    always_ff @(posedge clock) begin
        if (store) begin
            reg_mem[wr_ptr_q]  <= in_reg;
            data_mem[wr_ptr_q] <= in_data;
        end
    end

    wbq_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PW         (PW)
    ) u_match_a (
        .ent_reg_i  (reg_mem),
        .ent_data_i (data_mem),
        .valid_i    (valid_q),
        .wr_ptr_i   (wr_ptr_q),
        .query_i    (rd_addr_a),
        .hit_o      (fwd_hit_a),
        .data_o     (fwd_data_a)
    );

    wbq_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PW         (PW)
    ) u_match_b (
        .ent_reg_i  (reg_mem),
        .ent_data_i (data_mem),
        .valid_i    (valid_q),
        .wr_ptr_i   (wr_ptr_q),
        .query_i    (rd_addr_b),
        .hit_o      (fwd_hit_b),
        .data_o     (fwd_data_b)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_regfile_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        out_we;
    logic [4:0]  out_reg;
    logic [31:0] out_data;
    logic        out_ready;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_a;
    logic [31:0] fwd_data_b;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    // Reference model: pending writes, oldest at index 0.
    wb_entry_t q[$];

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .out_we     (out_we),
        .out_reg    (out_reg),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .count      (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to index a, searched from the back of the queue.
    function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd_idx == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endfunction

    // Compare every output against the model for the current (pre-edge) state.
    task automatic check_model(input string tag);
        int          n;
        logic        ha, hb;
        logic [31:0] da, db;
        n = q.size();
        model_fwd(rd_addr_a, ha, da);
        model_fwd(rd_addr_b, hb, db);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n < DEPTH));
        chk({tag, ".out_we"},   32'(out_we),   32'(n != 0));
        chk({tag, ".out_reg"},  32'(out_reg),  (n != 0) ? 32'(q[0].rd_idx) : 32'd0);
        chk({tag, ".out_data"}, out_data,      (n != 0) ? q[0].data : 32'd0);
        chk({tag, ".count"},    32'(count),    32'(n));
        chk({tag, ".hit_a"},    32'(fwd_hit_a), 32'(ha));
        chk({tag, ".data_a"},   fwd_data_a,     da);
        chk({tag, ".hit_b"},    32'(fwd_hit_b), 32'(hb));
        chk({tag, ".data_b"},   fwd_data_b,     db);
    endtask

    // One clock cycle: check, advance the model by the handshake rules, clock the DUT.
    task automatic cycle(input string tag);
        bit        do_push, do_pop;
        wb_entry_t e;
        #1;
        check_model(tag);
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = (q.size() != 0) && out_ready;
        if (do_pop) begin
            e = q.pop_front();
            $display("%0t %s write r%0d=%08h", $time, tag, e.rd_idx, e.data);
        end
        if (do_push) begin
            $display("%0t %s push r%0d=%08h", $time, tag, in_reg, in_data);
            if (in_reg != 5'd0) begin
                e.rd_idx = in_reg;
                e.data   = in_data;
                q.push_back(e);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_push(input logic v, input logic [4:0] r, input logic [31:0] d);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_reg    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd2;

        // Reset state
        @(negedge clock);
        #1;
        check_model("reset");
        reset = 1'b1;
        @(negedge clock);

        // Fill to full with the regfile stalled, then drain in order
        for (int i = 1; i <= 4; i++) begin
            set_push(1'b1, 5'(i), 32'(i * 'h11));
            cycle("fill");
        end
        set_push(1'b0, 5'd0, 32'd0);
        #1;
        chk("full.count", 32'(count), 32'd4);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain.out_reg", 32'(out_reg), 32'(i));
            chk("drain.out_data", out_data, 32'(i * 'h11));
            cycle("drain");
            if (i == 1) chk("drain.ready_back", 32'(in_ready), 32'd1);
        end
        cycle("empty");

        // Forwarding priority: younger write to the same register wins
        out_ready = 1'b0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd0;
        set_push(1'b1, 5'd5, 32'hA);
        cycle("fwd");
        set_push(1'b1, 5'd5, 32'hB);
        cycle("fwd");
        set_push(1'b0, 5'd0, 32'd0);
        #1;
        chk("fwd.hit_a", 32'(fwd_hit_a), 32'd1);
        chk("fwd.data_a", fwd_data_a, 32'hB);
        chk("fwd.hit_b", 32'(fwd_hit_b), 32'd0);
        chk("fwd.data_b", fwd_data_b, 32'd0);
        out_ready = 1'b1;
        cycle("fwd_drain");
        cycle("fwd_drain");

        // Write to r0 is accepted but dropped
        out_ready = 1'b0;
        set_push(1'b1, 5'd0, 32'hDEAD);
        #1;
        chk("r0.in_ready", 32'(in_ready), 32'd1);
        cycle("r0");
        set_push(1'b0, 5'd0, 32'd0);
        cycle("r0_after");
        chk("r0.count", 32'(count), 32'd0);
        chk("r0.out_we", 32'(out_we), 32'd0);

        // Full with simultaneous pop: push refused this cycle, accepted next
        for (int i = 6; i <= 9; i++) begin
            set_push(1'b1, 5'(i), 32'(i * 'h101));
            cycle("fill2");
        end
        set_push(1'b1, 5'd10, 32'h1234_5678);
        out_ready = 1'b1;
        rd_addr_a = 5'd10;
        #1;
        chk("fullpop.in_ready", 32'(in_ready), 32'd0);
        cycle("fullpop");
        chk("fullpop.count", 32'(count), 32'd3);
        cycle("fullpop_next");
        set_push(1'b0, 5'd0, 32'd0);
        out_ready = 1'b0;
        #1;
        chk("fullpop.count2", 32'(count), 32'd3);
        chk("fullpop.hit_a", 32'(fwd_hit_a), 32'd1);
        chk("fullpop.data_a", fwd_data_a, 32'h1234_5678);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("fullpop_drain");

        // Random traffic with stalls, exercising pointer wrap-around
        for (int i = 0; i < 300; i++) begin
            set_push($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 7));
            cycle("rnd");
            chk("rnd.count_max", 32'(count <= 3'd4), 32'd1);
        end

        // Asynchronous reset in the middle of traffic
        set_push(1'b0, 5'd0, 32'd0);
        out_ready = 1'b1;
        while (q.size() != 0) cycle("pre_rst_drain");
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_push(1'b1, 5'(i), 32'(i + 'h100));
            cycle("rst_fill");
        end
        set_push(1'b0, 5'd0, 32'd0);
        rd_addr_a = 5'd1;
        #2;
        chk("rst.pre_count", 32'(count), 32'd3);
        reset = 1'b0;
        #1;
        q.delete();
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.out_we", 32'(out_we), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.hit_a", 32'(fwd_hit_a), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cycle("post_rst");
        set_push(1'b1, 5'd7, 32'h77);
        cycle("post_rst_push");
        set_push(1'b0, 5'd0, 32'd0);
        cycle("post_rst_check");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
